// File: rtl/dt_pkg.sv
// Decision-tree engine package: node record layout, FSM state encoding and
// the built-in iris classification tree used at reset / as the fixed table.
package dt_pkg;

   localparam int FEAT_W    = 5;
   localparam int N_FEAT    = 4;
   localparam int N_NODES   = 32;
   localparam int CLASS_W   = 3;
   localparam int MAX_DEPTH = 8;
   localparam int NODE_W    = $clog2(N_NODES);
   localparam int FIDX_W    = $clog2(N_FEAT);
   localparam int NODE_BITS = 1 + FIDX_W + FEAT_W + 2*NODE_W + CLASS_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Field order fixes the cfg_data bit layout: is_leaf is the MSB, class the LSBs.
   typedef struct packed {
      logic                is_leaf;
      logic [FIDX_W-1:0]   feat_idx;
      logic [FEAT_W-1:0]   threshold;
      logic [NODE_W-1:0]   left;
      logic [NODE_W-1:0]   right;
      logic [CLASS_W-1:0]  cls;
   } node_t;

   typedef node_t [N_NODES-1:0] tree_t;

   function automatic node_t mk_int(int f, int t, int l, int r);
      node_t n;
      n.is_leaf   = 1'b0;
      n.feat_idx  = FIDX_W'(f);
      n.threshold = FEAT_W'(t);
      n.left      = NODE_W'(l);
      n.right     = NODE_W'(r);
      n.cls       = '0;
      return n;
   endfunction

   function automatic node_t mk_leaf(int c);
      node_t n;
      n           = '0;
      n.is_leaf   = 1'b1;
      n.cls       = CLASS_W'(c);
      return n;
   endfunction

   // Features: 0=sepal_length 1=sepal_width 2=petal_length 3=petal_width,
   // quantised to FEAT_W bits. Classes: 1=setosa 2=versicolor 3=virginica.
   // Unused slots are class-0 leaves so a stray index terminates cleanly.
   function automatic tree_t build_default_tree();
      tree_t t;
      for (int i = 0; i < N_NODES; i++) t[i] = mk_leaf(0);
      t[0]  = mk_int(3,  3,  1,  2);
      t[1]  = mk_leaf(1);
      t[2]  = mk_int(3,  6,  3,  4);
      t[3]  = mk_int(2,  9,  5,  6);
      t[4]  = mk_int(2, 15,  7,  8);
      t[5]  = mk_int(0,  4,  9, 10);
      t[6]  = mk_int(1,  8, 11, 12);
      t[7]  = mk_int(1, 10, 13, 14);
      t[8]  = mk_leaf(3);
      t[9]  = mk_leaf(3);
      t[10] = mk_leaf(2);
      t[11] = mk_int(0, 20, 15, 16);
      t[12] = mk_leaf(2);
      t[13] = mk_int(3,  8, 17, 18);
      t[14] = mk_leaf(3);
      t[15] = mk_leaf(2);
      t[16] = mk_leaf(3);
      t[17] = mk_int(0, 25, 19, 20);
      t[18] = mk_leaf(3);
      t[19] = mk_leaf(2);
      t[20] = mk_leaf(3);
      return t;
   endfunction

   localparam tree_t DEFAULT_TREE = build_default_tree();

endpackage

// File: rtl/dt_if.sv
// Sample-in / class-out handshake bundle for the decision-tree engine.
interface dt_if #(
   parameter int FEAT_W  = dt_pkg::FEAT_W,
   parameter int N_FEAT  = dt_pkg::N_FEAT,
   parameter int CLASS_W = dt_pkg::CLASS_W
) ();
   logic                       in_valid;
   logic                       in_ready;
   logic [N_FEAT*FEAT_W-1:0]   in_features;
   logic                       out_valid;
   logic                       out_ready;
   logic [CLASS_W-1:0]         out_class;
   logic                       out_err;

   modport master (
      output in_valid, in_features, out_ready,
      input  in_ready, out_valid, out_class, out_err
   );

   modport slave (
      input  in_valid, in_features, out_ready,
      output in_ready, out_valid, out_class, out_err
   );
endinterface

// File: rtl/dt_node_eval.sv
// Combinational single-node evaluator: picks the branch for an internal
// node, passes a leaf's class through, and flags bad feature index or
// depth exhaustion.
module dt_node_eval
   import dt_pkg::*;
#(
   parameter int FEAT_W    = dt_pkg::FEAT_W,
   parameter int N_FEAT    = dt_pkg::N_FEAT,
   parameter int MAX_DEPTH = dt_pkg::MAX_DEPTH,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
   input  node_t                     node,
   input  logic [N_FEAT*FEAT_W-1:0]  features,
   input  logic [DEPTH_W-1:0]        depth,
   output logic                      is_leaf,
   output logic                      err,
   output logic [NODE_W-1:0]         next_node,
   output logic [CLASS_W-1:0]        cls
);

   logic [FEAT_W-1:0] feat_val;
   logic              idx_bad;

   // Select the addressed feature and resolve branch / leaf / error.
   always_comb begin
      feat_val = '0;
      for (int i = 0; i < N_FEAT; i++)
         if (int'(node.feat_idx) == i) feat_val = features[i*FEAT_W +: FEAT_W];
      idx_bad   = int'(node.feat_idx) >= N_FEAT;
      is_leaf   = node.is_leaf;
      cls       = node.cls;
      err       = !node.is_leaf && (idx_bad || int'(depth) >= MAX_DEPTH);
      next_node = (feat_val <= node.threshold) ? node.left : node.right;
   end

endmodule

// File: rtl/dt_engine.sv
// Decision-tree inference engine: accepts a feature vector, walks the node
// table one node per cycle and returns the leaf class (or an error).
// Optional macro DT_PROG_EN makes the node table a reset-loaded register
// file writable through the cfg_* port while idle.
module dt_engine
   import dt_pkg::*;
#(
   parameter int FEAT_W    = dt_pkg::FEAT_W,
   parameter int N_FEAT    = dt_pkg::N_FEAT,
   parameter int N_NODES   = dt_pkg::N_NODES,
   parameter int CLASS_W   = dt_pkg::CLASS_W,
   parameter int MAX_DEPTH = dt_pkg::MAX_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
`ifdef DT_PROG_EN
   input  logic                          cfg_we,
   input  logic [$clog2(N_NODES)-1:0]    cfg_addr,
   input  logic [NODE_BITS-1:0]          cfg_data,
`endif
   dt_if.slave                           bus
);

   localparam int NODE_IDX_W = $clog2(N_NODES);
   localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] WALK = ST_WALK;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]                 state;
   logic [NODE_IDX_W-1:0]      node_idx;
   logic [DEPTH_W-1:0]         depth;
   logic [N_FEAT*FEAT_W-1:0]   feat_q;
   logic                       out_valid_r;
   logic                       out_err_r;
   logic [CLASS_W-1:0]         out_class_r;
   logic                       cfg_we_i;
   tree_t                      tbl;
   node_t                      cur_node;
   logic                       ev_leaf;
   logic                       ev_err;
   logic [NODE_W-1:0]          ev_next;
   logic [CLASS_W-1:0]         ev_cls;

`ifdef DT_PROG_EN
   assign cfg_we_i = cfg_we;

   // Node table registers: reloaded on reset, writable only while idle.
   always_ff @(posedge clk) begin
      if (reset)
         tbl <= DEFAULT_TREE;
      else if (state == IDLE && cfg_we)
         tbl[cfg_addr] <= node_t'(cfg_data);
   end
`else
   assign cfg_we_i = 1'b0;
   assign tbl      = DEFAULT_TREE;
`endif

   assign cur_node = tbl[node_idx];

   dt_node_eval #(
      .FEAT_W    (FEAT_W),
      .N_FEAT    (N_FEAT),
      .MAX_DEPTH (MAX_DEPTH),
      .DEPTH_W   (DEPTH_W)
   ) u_eval (
      .node      (cur_node),
      .features  (feat_q),
      .depth     (depth),
      .is_leaf   (ev_leaf),
      .err       (ev_err),
      .next_node (ev_next),
      .cls       (ev_cls)
   );

   // A config write takes priority over accepting a sample in the same cycle.
   assign bus.in_ready  = (state == IDLE) && !cfg_we_i;
   assign bus.out_valid = out_valid_r;
   assign bus.out_class = out_class_r;
   assign bus.out_err   = out_err_r;

   // Control FSM: accept, walk one node per cycle, hold result until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         out_valid_r <= 1'b0;
         out_class_r <= '0;
         out_err_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  feat_q   <= bus.in_features;
                  node_idx <= '0;
                  depth    <= '0;
                  state    <= WALK;
               end
            end
            WALK: begin
               if (ev_leaf) begin
                  out_class_r <= ev_cls;
                  out_err_r   <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else if (ev_err) begin
                  out_class_r <= '0;
                  out_err_r   <= 1'b1;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  node_idx <= NODE_IDX_W'(ev_next);
                  depth    <= depth + DEPTH_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_engine.sv
// Directed bench for dt_engine using the built-in iris tree; the
// programmable-table steps are compiled only when DT_PROG_EN is defined.
module tb_dt_engine;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   dt_if dif ();

`ifdef DT_PROG_EN
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [20:0] cfg_data;
`endif

   dt_engine dut (
      .clk      (clk),
      .reset    (reset),
`ifdef DT_PROG_EN
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
`endif
      .bus      (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [19:0] pk(int sl, int sw, int pl, int pw);
      return {5'(pw), 5'(pl), 5'(sw), 5'(sl)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one sample, measure latency, optionally hold off out_ready
   // (pushing a competing sample meanwhile), then complete the handshake.
   task automatic run(input string tag, input logic [19:0] f, input int exp_cls,
                      input int exp_err, input int exp_lat, input int hold);
      int lat;
      check({tag, "_rdy"}, 32'(dif.in_ready), 32'd1);
      dif.in_features = f;
      dif.in_valid    = 1'b1;
      step();
      dif.in_valid    = 1'b0;
      check({tag, "_busy"}, 32'(dif.in_ready), 32'd0);
      lat = 0;
      while (!dif.out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_cls"}, 32'(dif.out_class), 32'(exp_cls));
      check({tag, "_err"}, 32'(dif.out_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         dif.in_valid    = 1'b1;
         dif.in_features = pk(31, 31, 31, 31);
         step();
         check({tag, "_hold_cls"}, 32'(dif.out_class), 32'(exp_cls));
         check({tag, "_hold_vld"}, 32'(dif.out_valid), 32'd1);
         check({tag, "_hold_rdy"}, 32'(dif.in_ready), 32'd0);
      end
      dif.in_valid  = 1'b0;
      dif.out_ready = 1'b1;
      step();
      dif.out_ready = 1'b0;
      check({tag, "_vld_clr"}, 32'(dif.out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(dif.in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      reset           = 1'b1;
      dif.in_valid    = 1'b0;
      dif.in_features = '0;
      dif.out_ready   = 1'b0;
`ifdef DT_PROG_EN
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
`endif
      step();
      step();
      reset = 1'b0;
      check("rst_vld", 32'(dif.out_valid), 32'd0);
      check("rst_cls", 32'(dif.out_class), 32'd0);
      check("rst_err", 32'(dif.out_err), 32'd0);
      step();
      check("rst_rdy", 32'(dif.in_ready), 32'd1);

      // Root split only: setosa.
      run("pw2",      pk(0, 0, 0, 2),     1, 0, 2, 0);
      run("pw3_edge", pk(0, 0, 0, 3),     1, 0, 2, 0);
      run("pw4_edge", pk(0, 0, 0, 4),     3, 0, 5, 0);
      // Four internal nodes, with 10 cycles of back-pressure.
      run("pw5pl8",   pk(0, 0, 8, 5),     3, 0, 5, 10);
      run("pw5pl8sl5",pk(5, 0, 8, 5),     2, 0, 5, 0);
      run("deep_c3",  pk(9, 5, 12, 10),   3, 0, 6, 0);
      run("deep_c2",  pk(10, 3, 12, 5),   2, 0, 6, 0);
      run("big",      pk(0, 0, 20, 20),   3, 0, 4, 0);
      run("sl30",     pk(30, 2, 14, 7),   3, 0, 7, 0);
      run("sl25_edge",pk(25, 2, 14, 7),   2, 0, 7, 0);
      run("all31",    pk(31, 31, 31, 31), 3, 0, 4, 0);

      // Reset two cycles into a walk aborts the sample.
      dif.in_features = pk(0, 0, 8, 5);
      dif.in_valid    = 1'b1;
      step();
      dif.in_valid    = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_vld", 32'(dif.out_valid), 32'd0);
      check("abort_cls", 32'(dif.out_class), 32'd0);
      check("abort_rdy", 32'(dif.in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (dif.out_valid) seen++;
      end
      check("abort_no_out", 32'(seen), 32'd0);
      run("post_abort", pk(0, 0, 0, 2), 1, 0, 2, 0);

`ifdef DT_PROG_EN
      // Write node 0 as leaf class 5 while offering a sample: write wins.
      cfg_we          = 1'b1;
      cfg_addr        = 5'd0;
      cfg_data        = 21'h100005;
      dif.in_features = pk(0, 0, 0, 2);
      dif.in_valid    = 1'b1;
      check("wr_rdy_low", 32'(dif.in_ready), 32'd0);
      step();
      cfg_we       = 1'b0;
      dif.in_valid = 1'b0;
      check("wr_no_acc_rdy", 32'(dif.in_ready), 32'd1);
      step();
      check("wr_no_acc_vld", 32'(dif.out_valid), 32'd0);
      run("leaf5", pk(0, 0, 0, 2), 5, 0, 1, 0);

      // Writes attempted during WALK and DONE must be ignored.
      dif.in_valid = 1'b1;
      step();
      dif.in_valid = 1'b0;
      cfg_we       = 1'b1;
      cfg_data     = 21'h100002;
      step();
      step();
      cfg_we = 1'b0;
      check("busy_wr_cls", 32'(dif.out_class), 32'd5);
      dif.out_ready = 1'b1;
      step();
      dif.out_ready = 1'b0;
      run("leaf5_kept", pk(3, 3, 3, 3), 5, 0, 1, 0);

      // Node 0 internal looping on itself: depth exhaustion.
      cfg_we   = 1'b1;
      cfg_data = 21'h000000;
      step();
      cfg_we = 1'b0;
      run("loop_err", pk(1, 2, 3, 4), 0, 1, 9, 0);

      // Reset restores the built-in tree.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      run("reload", pk(0, 0, 0, 2), 1, 0, 2, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
